// File: rtl/aeolus_pkg.sv
// rtl/aeolus_pkg.sv - shared opcodes, state encoding and default parameters for the Aeolus core
package aeolus_pkg;

   localparam int DEF_DATA_W       = 4;
   localparam int DEF_ADDR_W       = 4;
   localparam bit DEF_HALT_ON_WRAP = 1'b0;

   localparam logic [3:0] OP_LDA  = 4'd0;
   localparam logic [3:0] OP_LDB  = 4'd1;
   localparam logic [3:0] OP_LDO  = 4'd2;
   localparam logic [3:0] OP_LDSA = 4'd3;
   localparam logic [3:0] OP_LDSB = 4'd4;
   localparam logic [3:0] OP_LSH  = 4'd5;
   localparam logic [3:0] OP_RSH  = 4'd6;
   localparam logic [3:0] OP_CLR  = 4'd7;
   localparam logic [3:0] OP_SNZA = 4'd8;
   localparam logic [3:0] OP_SNZS = 4'd9;
   localparam logic [3:0] OP_ADD  = 4'd10;
   localparam logic [3:0] OP_SUB  = 4'd11;
   localparam logic [3:0] OP_AND  = 4'd12;
   localparam logic [3:0] OP_OR   = 4'd13;
   localparam logic [3:0] OP_XOR  = 4'd14;
   localparam logic [3:0] OP_INV  = 4'd15;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   // Only the two load opcodes wait on the operand handshake.
   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_LDB);
   endfunction

endpackage

// File: rtl/aeolus_alu_n.sv
// rtl/aeolus_alu_n.sv - combinational ALU: accumulator/shift result plus next carry and SF
module aeolus_alu_n
   import aeolus_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [3:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [DATA_W-1:0] i_sr,
   input  logic              i_carry,
   input  logic              i_sf,
   output logic [DATA_W-1:0] o_res,
   output logic              o_carry,
   output logic              o_sf
);

   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;

   // The extra top bit of the difference is the borrow, set exactly when A < B.
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   // o_res is the new SR for shifts and the new ACC otherwise; flags pass through unless touched.
   always_comb begin
      o_res   = '0;
      o_carry = i_carry;
      o_sf    = i_sf;
      case (i_op)
         OP_LSH: begin
            o_res = {i_sr[DATA_W-2:0], 1'b0};
            o_sf  = i_sr[DATA_W-1];
         end
         OP_RSH: begin
            o_res = {1'b0, i_sr[DATA_W-1:1]};
            o_sf  = i_sr[0];
         end
         OP_ADD:  {o_carry, o_res} = w_sum;
         OP_SUB:  {o_carry, o_res} = w_diff;
         OP_AND:  o_res = i_a & i_b;
         OP_OR:   o_res = i_a | i_b;
         OP_XOR:  o_res = i_a ^ i_b;
         OP_INV:  o_res = ~i_a;
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/aeolus_mc_core.sv
// rtl/aeolus_mc_core.sv - multi-cycle Aeolus accumulator core with ROM fetch port and operand handshake
module aeolus_mc_core
   import aeolus_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter bit HALT_ON_WRAP = DEF_HALT_ON_WRAP
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   input  logic [3:0]        rom_data,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              carry,
   output logic              shift_flag,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [3:0]        r_ir;
   logic [DATA_W-1:0] r_a, r_b, r_acc, r_sr, r_out;
   logic              r_sf, r_carry, r_out_valid;

   logic              w_is_load, w_skip, w_wrap, w_exec_done;
   logic [ADDR_W:0]   w_pc_inc;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_carry, w_alu_sf;

   assign w_is_load = is_load(r_ir);
   assign w_skip    = ((r_ir == OP_SNZA) && (r_a != '0)) || ((r_ir == OP_SNZS) && r_sf);
   // One extra bit catches the carry out of the PC, which is the wrap event.
   assign w_pc_inc  = {1'b0, r_pc} + (w_skip ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
   assign w_wrap    = w_pc_inc[ADDR_W];

   aeolus_alu_n #(.DATA_W(DATA_W)) u_alu (
      .i_op    (r_ir),
      .i_a     (r_a),
      .i_b     (r_b),
      .i_sr    (r_sr),
      .i_carry (r_carry),
      .i_sf    (r_sf),
      .o_res   (w_alu_res),
      .o_carry (w_alu_carry),
      .o_sf    (w_alu_sf)
   );

   // Next-state and strobes; rom_en is masked while reset is held so the port is quiet in reset.
   always_comb begin
      w_state_nxt = r_state;
      rom_en      = 1'b0;
      in_ready    = 1'b0;
      w_exec_done = 1'b0;
      case (r_state)
         ST_FETCH: begin
            rom_en      = !reset;
            w_state_nxt = ST_DECODE;
         end
         ST_DECODE: w_state_nxt = ST_EXEC;
         ST_EXEC: begin
            in_ready    = w_is_load;
            w_exec_done = !w_is_load || in_valid;
            if (w_exec_done) begin
               w_state_nxt = (HALT_ON_WRAP && w_wrap) ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_FETCH;
      else       r_state <= w_state_nxt;
   end

   // Datapath: IR loads in DECODE, architectural state commits only when EXEC completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= '0;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_sr        <= '0;
         r_out       <= '0;
         r_sf        <= 1'b0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (r_state == ST_DECODE) r_ir <= rom_data;
         if ((r_state == ST_EXEC) && w_exec_done) begin
            r_pc    <= w_pc_inc[ADDR_W-1:0];
            r_carry <= w_alu_carry;
            r_sf    <= w_alu_sf;
            case (r_ir)
               OP_LDA:  r_a <= in_data;
               OP_LDB:  r_b <= in_data;
               OP_LDO: begin
                  r_out       <= r_acc;
                  r_out_valid <= 1'b1;
               end
               OP_LDSA: r_sr <= r_a;
               OP_LDSB: r_sr <= r_b;
               OP_LSH, OP_RSH: r_sr <= w_alu_res;
               OP_CLR:  r_acc <= '0;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INV: r_acc <= w_alu_res;
               default: ;
            endcase
         end
      end
   end

   assign rom_addr   = r_pc;
   assign pc         = r_pc;
   assign out_data   = r_out;
   assign out_valid  = r_out_valid;
   assign carry      = r_carry;
   assign shift_flag = r_sf;
   assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_aeolus_mc_core.sv
// tb/tb_aeolus_mc_core.sv - directed and randomized checks of aeolus_mc_core against a schedule model
`timescale 1ns/1ps
module tb_aeolus_mc_core;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NC = 160;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [3:0]    rom [16];

   // Variant 0 halts on wrap, variant 1 keeps running; both see the same program and operands.
   logic [AW-1:0] v_addr  [2];
   logic          v_en    [2];
   logic [3:0]    v_rdata [2];
   logic          v_rdy   [2];
   logic [DW-1:0] v_out   [2];
   logic          v_ov    [2];
   logic          v_cy    [2];
   logic          v_sf    [2];
   logic          v_hlt   [2];
   logic [AW-1:0] v_pc    [2];

   aeolus_mc_core #(.DATA_W(DW), .ADDR_W(AW), .HALT_ON_WRAP(1'b1)) dut (
      .clk(clk), .reset(reset), .rom_addr(v_addr[0]), .rom_en(v_en[0]), .rom_data(v_rdata[0]),
      .in_data(in_data), .in_valid(in_valid), .in_ready(v_rdy[0]), .out_data(v_out[0]),
      .out_valid(v_ov[0]), .carry(v_cy[0]), .shift_flag(v_sf[0]), .halted(v_hlt[0]), .pc(v_pc[0]));

   aeolus_mc_core #(.DATA_W(DW), .ADDR_W(AW), .HALT_ON_WRAP(1'b0)) dut_free (
      .clk(clk), .reset(reset), .rom_addr(v_addr[1]), .rom_en(v_en[1]), .rom_data(v_rdata[1]),
      .in_data(in_data), .in_valid(in_valid), .in_ready(v_rdy[1]), .out_data(v_out[1]),
      .out_valid(v_ov[1]), .carry(v_cy[1]), .shift_flag(v_sf[1]), .halted(v_hlt[1]), .pc(v_pc[1]));

   // Synchronous program ROM, one per core.
   always @(posedge clk) begin
      if (v_en[0]) v_rdata[0] <= rom[v_addr[0]];
      if (v_en[1]) v_rdata[1] <= rom[v_addr[1]];
   end

   bit          iv [NC];
   logic [7:0]  id [NC];

   bit          e_en  [2][NC];
   bit          e_rdy [2][NC];
   bit          e_ov  [2][NC];
   bit          e_cy  [2][NC];
   bit          e_sf  [2][NC];
   bit          e_hlt [2][NC];
   logic [7:0]  e_out [2][NC];
   int          e_pc  [2][NC];

   bit          obs_en [NC], obs_rdy [NC], obs_ov [NC], obs_cy [NC], obs_sf [NC], obs_hlt [NC];
   logic [7:0]  obs_out [NC];
   int          obs_pc [NC], obs_pc_f [NC];
   bit          obs_en_f [NC];

   int n_chk = 0;
   int n_bad = 0;
   int cur_cyc = 0;
   int cur_var = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s var=%0d cycle=%0d got=%0h exp=%0h", tag, cur_var, cur_cyc, got, exp);
      end
   endtask

   // Instruction-level model: each instruction takes fetch t, exec from t+2 until its operand
   // arrives, and its effects appear in the cycle after exec, which is also the next fetch.
   task automatic build_model(input int v);
      int  t, e, pc, op, nxt, a, b, acc, sr, out_r;
      bit  cy, sf, ovp, skip;
      t = 0; pc = 0; a = 0; b = 0; acc = 0; sr = 0; out_r = 0;
      cy = 0; sf = 0; ovp = 0;
      for (int c = 0; c < NC; c++) begin
         e_en[v][c] = 0; e_rdy[v][c] = 0; e_ov[v][c] = 0; e_cy[v][c] = 0;
         e_sf[v][c] = 0; e_hlt[v][c] = 0; e_out[v][c] = '0; e_pc[v][c] = 0;
      end
      while (t < NC) begin
         op = int'(rom[pc]);
         e = t + 2;
         if (op <= 1) while (e < NC && !iv[e]) e++;
         for (int c = t; c <= e && c < NC; c++) begin
            e_en[v][c]  = (c == t);
            e_rdy[v][c] = (op <= 1) && (c >= t + 2);
            e_ov[v][c]  = ovp && (c == t);
            e_out[v][c] = 8'(out_r);
            e_cy[v][c]  = cy;
            e_sf[v][c]  = sf;
            e_pc[v][c]  = pc;
         end
         ovp = 0;
         if (e >= NC) break;
         skip = 0;
         case (op)
            0:  a = int'(id[e]);
            1:  b = int'(id[e]);
            2:  begin out_r = acc; ovp = 1; end
            3:  sr = a;
            4:  sr = b;
            5:  begin sf = sr[7]; sr = (sr * 2) % 256; end
            6:  begin sf = sr[0]; sr = sr / 2; end
            7:  acc = 0;
            8:  skip = (a != 0);
            9:  skip = sf;
            10: begin cy = (a + b) > 255; acc = (a + b) % 256; end
            11: begin cy = a < b; acc = (a - b + 256) % 256; end
            12: acc = a & b;
            13: acc = a | b;
            14: acc = a ^ b;
            default: acc = 255 - a;
         endcase
         nxt = pc + (skip ? 2 : 1);
         pc  = nxt % 16;
         t   = e + 1;
         if (nxt >= 16 && v == 0) begin
            for (int c = t; c < NC; c++) begin
               e_ov[v][c]  = ovp && (c == t);
               e_out[v][c] = 8'(out_r);
               e_cy[v][c]  = cy;
               e_sf[v][c]  = sf;
               e_pc[v][c]  = pc;
               e_hlt[v][c] = 1;
            end
            break;
         end
      end
   endtask

   task automatic check_reset_outputs();
      for (int v = 0; v < 2; v++) begin
         cur_var = v;
         check_eq("rst_rom_en",    32'(v_en[v]),   32'd0);
         check_eq("rst_rom_addr",  32'(v_addr[v]), 32'd0);
         check_eq("rst_in_ready",  32'(v_rdy[v]),  32'd0);
         check_eq("rst_out_valid", 32'(v_ov[v]),   32'd0);
         check_eq("rst_out_data",  32'(v_out[v]),  32'd0);
         check_eq("rst_carry",     32'(v_cy[v]),   32'd0);
         check_eq("rst_sf",        32'(v_sf[v]),   32'd0);
         check_eq("rst_halted",    32'(v_hlt[v]),  32'd0);
         check_eq("rst_pc",        32'(v_pc[v]),   32'd0);
      end
   endtask

   // Reset, release, then compare every cycle; when rst_at is reached reset is raised instead.
   task automatic run_prog(input int rst_at);
      build_model(0);
      build_model(1);
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < NC; c++) begin
         cur_cyc = c;
         in_valid = iv[c];
         in_data  = id[c];
         if (c == rst_at) begin
            reset = 1'b1;
            break;
         end
         @(negedge clk);
         obs_en[c] = v_en[0]; obs_rdy[c] = v_rdy[0]; obs_ov[c] = v_ov[0]; obs_cy[c] = v_cy[0];
         obs_sf[c] = v_sf[0]; obs_hlt[c] = v_hlt[0]; obs_out[c] = v_out[0];
         obs_pc[c] = int'(v_pc[0]); obs_pc_f[c] = int'(v_pc[1]); obs_en_f[c] = v_en[1];
         for (int v = 0; v < 2; v++) begin
            cur_var = v;
            check_eq("rom_en",     32'(v_en[v]),   32'(e_en[v][c]));
            check_eq("rom_addr",   32'(v_addr[v]), e_pc[v][c]);
            check_eq("pc",         32'(v_pc[v]),   e_pc[v][c]);
            check_eq("in_ready",   32'(v_rdy[v]),  32'(e_rdy[v][c]));
            check_eq("out_valid",  32'(v_ov[v]),   32'(e_ov[v][c]));
            check_eq("out_data",   32'(v_out[v]),  32'(e_out[v][c]));
            check_eq("carry",      32'(v_cy[v]),   32'(e_cy[v][c]));
            check_eq("shift_flag", 32'(v_sf[v]),   32'(e_sf[v][c]));
            check_eq("halted",     32'(v_hlt[v]),  32'(e_hlt[v][c]));
         end
         @(posedge clk);
         #1;
      end
      cur_var = 0;
   endtask

   task automatic fill(input logic [3:0] op, input bit valid);
      for (int i = 0; i < 16; i++) rom[i] = op;
      for (int c = 0; c < NC; c++) begin
         iv[c] = valid;
         id[c] = 8'($urandom);
      end
   endtask

   initial begin
      fill(4'd7, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      cur_cyc = -1;
      check_reset_outputs();

      // LDA, LDB, ADD, LDO with no stalls.
      fill(4'd7, 1'b1);
      rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10; rom[3] = 4'd2;
      id[2] = 8'h5A; id[5] = 8'h3C;
      run_prog(NC);
      cur_cyc = 0;  check_eq("d1_first_rom_en", 32'(obs_en[0]), 32'd1);
      cur_cyc = 0;  check_eq("d1_first_addr", 32'(obs_pc[0]), 32'd0);
      cur_cyc = 11; check_eq("d1_ov_before", 32'(obs_ov[11]), 32'd0);
      cur_cyc = 12; check_eq("d1_ov", 32'(obs_ov[12]), 32'd1);
      cur_cyc = 12; check_eq("d1_out", 32'(obs_out[12]), 32'h96);
      cur_cyc = 12; check_eq("d1_carry", 32'(obs_cy[12]), 32'd0);
      cur_cyc = 13; check_eq("d1_ov_after", 32'(obs_ov[13]), 32'd0);

      // SUB borrow, ADD overflow, shift into SF, SNZS skipping an LDO.
      fill(4'd7, 1'b1);
      rom[0] = 4'd0;  rom[1] = 4'd1;  rom[2] = 4'd11; rom[3] = 4'd2;
      rom[4] = 4'd0;  rom[5] = 4'd1;  rom[6] = 4'd10; rom[7] = 4'd2;
      rom[8] = 4'd0;  rom[9] = 4'd3;  rom[10] = 4'd5; rom[11] = 4'd9;
      rom[12] = 4'd2; rom[13] = 4'd7; rom[14] = 4'd2;
      id[2] = 8'h10; id[5] = 8'h20; id[14] = 8'hFF; id[17] = 8'h01; id[26] = 8'h81;
      run_prog(NC);
      cur_cyc = 12; check_eq("d2_sub_out", 32'(obs_out[12]), 32'hF0);
      cur_cyc = 12; check_eq("d2_sub_borrow", 32'(obs_cy[12]), 32'd1);
      cur_cyc = 24; check_eq("d2_add_ov", 32'(obs_ov[24]), 32'd1);
      cur_cyc = 24; check_eq("d2_add_out", 32'(obs_out[24]), 32'h00);
      cur_cyc = 24; check_eq("d2_add_carry", 32'(obs_cy[24]), 32'd1);
      cur_cyc = 33; check_eq("d2_lsh_sf", 32'(obs_sf[33]), 32'd1);
      cur_cyc = 36; check_eq("d2_skip_pc", 32'(obs_pc[36]), 32'd13);
      cur_cyc = 39; check_eq("d2_skipped_ldo", 32'(obs_ov[39]), 32'd0);

      // LDA stalled for five EXEC cycles, then 0x07 arrives and is routed to OUT via OR.
      fill(4'd7, 1'b1);
      rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd13; rom[3] = 4'd2;
      for (int c = 2; c <= 6; c++) iv[c] = 1'b0;
      id[7] = 8'h07; id[10] = 8'h00;
      run_prog(NC);
      for (int c = 2; c <= 7; c++) begin
         cur_cyc = c;
         check_eq("d3_stall_ready", 32'(obs_rdy[c]), 32'd1);
         check_eq("d3_stall_pc", 32'(obs_pc[c]), 32'd0);
      end
      cur_cyc = 8;  check_eq("d3_ready_drop", 32'(obs_rdy[8]), 32'd0);
      cur_cyc = 17; check_eq("d3_out", 32'(obs_out[17]), 32'h07);

      // Sixteen CLRs: one core halts at the wrap, the other restarts from address 0.
      fill(4'd7, 1'b0);
      run_prog(NC);
      cur_cyc = 47; check_eq("d4_not_yet_halted", 32'(obs_hlt[47]), 32'd0);
      cur_cyc = 48; check_eq("d4_halted", 32'(obs_hlt[48]), 32'd1);
      cur_cyc = 48; check_eq("d4_halt_pc", 32'(obs_pc[48]), 32'd0);
      cur_cyc = 48; check_eq("d4_halt_rom_en", 32'(obs_en[48]), 32'd0);
      cur_cyc = NC - 1; check_eq("d4_halt_rom_en_late", 32'(obs_en[NC-1]), 32'd0);
      cur_cyc = 48; check_eq("d4_free_rom_en", 32'(obs_en_f[48]), 32'd1);
      cur_cyc = 48; check_eq("d4_free_pc", 32'(obs_pc_f[48]), 32'd0);

      // Reset raised during an LDA stall, together with a valid operand.
      fill(4'd7, 1'b0);
      rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10; rom[3] = 4'd2; rom[4] = 4'd0;
      iv[2] = 1'b1; id[2] = 8'hF0; iv[5] = 1'b1; id[5] = 8'h20; iv[18] = 1'b1; id[18] = 8'h55;
      run_prog(18);
      cur_cyc = 15; check_eq("d5_out_before", 32'(obs_out[15]), 32'h10);
      cur_cyc = 16; check_eq("d5_stalling", 32'(obs_rdy[16]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cur_cyc = 18;
      check_reset_outputs();
      @(posedge clk);
      #1 reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      cur_cyc = 0;
      for (int v = 0; v < 2; v++) begin
         cur_var = v;
         check_eq("d5_restart_rom_en", 32'(v_en[v]), 32'd1);
         check_eq("d5_restart_addr", 32'(v_addr[v]), 32'd0);
      end
      cur_var = 0;

      // Random programs and random operand availability.
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
         for (int c = 0; c < NC; c++) begin
            iv[c] = ($urandom_range(0, 2) != 0);
            id[c] = 8'($urandom);
         end
         run_prog(NC);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
